// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus master/slave ports.
// It holds the state encoding, the default widths and the bit order used on the wire.
package bus_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 4;
    localparam bit LSB_FIRST  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        SEND,
        WAIT_RESP,
        RECV,
        DONE
    } state_t;
endpackage

// File: rtl/master_port_if.sv
// Serial bus signals between an initiator port and the slave/interconnect side.
interface master_port_if;
    logic read_en;
    logic write_en;
    logic master_valid;
    logic slave_ready;
    logic tx_address;
    logic tx_data;
    logic slave_valid;
    logic master_ready;
    logic rx_data;
    logic split_en;
    logic split_wait;

    modport master (
        output read_en, write_en, master_valid, tx_address, tx_data,
               master_ready, split_wait,
        input  slave_ready, slave_valid, rx_data, split_en
    );

    modport slave (
        input  read_en, write_en, master_valid, tx_address, tx_data,
               master_ready, split_wait,
        output slave_ready, slave_valid, rx_data, split_en
    );
endinterface

// File: rtl/master_in_port.sv
// Serial-in/parallel-out receiver for read data, with its own bit counter.
// The final shift and the load into rdata happen on the same edge.
module master_in_port
    import bus_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              load_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] rdata,
    output logic              last
);
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] sr_nxt;
    logic [CNT_W-1:0]  cnt;

    assign sr_nxt = LSB_FIRST ? {rx_bit, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], rx_bit};
    assign last   = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (shift_en) begin
            sr <= sr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            rdata <= '0;
        end else begin
            cnt <= shift_en ? cnt + 1'b1 : '0;
            if (load_en) begin
                rdata <= sr_nxt;
            end
        end
    end
endmodule

// File: rtl/master_port.sv
// Initiator-side serial bus port: takes one local read/write request, serialises
// address and write data onto the bus, and collects split/serial read responses.
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_read,
    input  logic              start_write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] rdata,
    master_port_if.master     bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_nxt;
    logic              err_q;
    logic              err_nxt;
    logic              is_read;
    logic              split_q;
    logic [CNT_W-1:0]  send_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] data_sr;
    logic              accept;
    logic              send_last;
    logic              tmo_last;
    logic              rx_shift;
    logic              rx_load;
    logic              rx_last;

    assign accept    = (state == IDLE) && (start_read ^ start_write);
    assign send_last = (send_cnt == CNT_W'(ADDR_W - 1));
    assign tmo_last  = (tmo_cnt == TW'(TIMEOUT - 1));
    assign rx_shift  = ((state == WAIT_RESP) && bus.slave_valid) || (state == RECV);
    assign rx_load   = (state == RECV) && rx_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            err_q   <= 1'b0;
            is_read <= 1'b0;
            split_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            if (accept) begin
                is_read <= start_read;
            end
            // Split flag lives only while we stay in WAIT_RESP.
            split_q <= (state == WAIT_RESP) && (state_nxt == WAIT_RESP) &&
                       (split_q || bus.split_en);
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start_read && start_write) begin
                    err_nxt = 1'b1;
                end else if (start_read || start_write) begin
                    state_nxt = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (bus.slave_ready) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (send_last) begin
                    state_nxt = is_read ? WAIT_RESP : DONE;
                end
            end
            WAIT_RESP: begin
                if (bus.slave_valid) begin
                    state_nxt = RECV;
                end else if (tmo_last) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            RECV: begin
                if (rx_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy             = (state != IDLE);
        done             = (state == DONE);
        error            = err_q;
        bus.read_en      = is_read && ((state == WAIT_READY) || (state == SEND));
        bus.write_en     = !is_read && ((state == WAIT_READY) || (state == SEND));
        bus.master_valid = (state == SEND);
        bus.tx_address   = (state == SEND) &&
                           (LSB_FIRST ? addr_sr[0] : addr_sr[ADDR_W-1]);
        bus.tx_data      = (state == SEND) && !is_read &&
                           (LSB_FIRST ? data_sr[0] : data_sr[DATA_W-1]);
        bus.master_ready = (state == WAIT_RESP) || (state == RECV);
        bus.split_wait   = split_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            send_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            send_cnt <= (state == SEND) ? send_cnt + 1'b1 : '0;
            tmo_cnt  <= (state == WAIT_RESP) ? tmo_cnt + 1'b1 : '0;
        end
    end

    // Write data shifts in zeros, so tx_data falls to 0 once DATA_W bits are out.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_sr <= addr_in;
            data_sr <= start_write ? wdata_in : '0;
        end else if (state == SEND) begin
            addr_sr <= LSB_FIRST ? (addr_sr >> 1) : (addr_sr << 1);
            data_sr <= LSB_FIRST ? (data_sr >> 1) : (data_sr << 1);
        end
    end

    master_in_port #(
        .DATA_W (DATA_W)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .shift_en (rx_shift),
        .load_en  (rx_load),
        .rx_bit   (bus.rx_data),
        .rdata    (rdata),
        .last     (rx_last)
    );
endmodule

// File: tb/tb_master_port.sv
// Bench for master_port: a table of directed transactions, hand sequences for
// the illegal-request and reset-abort cases, then randomised transactions.
module tb_master_port;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_read;
    logic        start_write;
    logic [11:0] addr_in;
    logic [7:0]  wdata_in;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  rdata;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mdl_rdata = 8'h00;

    typedef struct {
        bit         is_read;
        logic [11:0] addr;
        logic [7:0] wdata;
        logic [7:0] rbits;
        int         rdy_dly;
        int         resp_dly;
        int         split_at;
        int         exp_end;
        logic [7:0] exp_rdata;
    } vec_t;

    master_port_if bus();

    master_port #(
        .ADDR_W  (12),
        .DATA_W  (8),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_read  (start_read),
        .start_write (start_write),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .rdata       (rdata),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] sample();
        return {busy, done, error, bus.read_en, bus.write_en, bus.master_valid,
                bus.tx_address, bus.tx_data, bus.master_ready, bus.split_wait, rdata};
    endfunction

    task automatic check(input string name, input int c, input logic [17:0] act,
                         input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, c, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start_read      = 1'b0;
        start_write     = 1'b0;
        bus.slave_ready = 1'b0;
        bus.slave_valid = 1'b0;
        bus.rx_data     = 1'b0;
        bus.split_en    = 1'b0;
    endtask

    // Expected behaviour is laid out as a timeline of phase lengths counted in
    // cycles after the edge that accepts the request.
    task automatic run_txn(input vec_t t, output int obs_end);
        int          w, s, end_c, last_wr, i;
        bit          tmo, e_busy, e_done, e_err, e_en, e_mv, e_txa, e_txd, e_mr, e_sw;
        logic [7:0]  rd_exp;
        logic [17:0] exp;
        w       = t.rdy_dly + 1;
        tmo     = t.is_read && (t.resp_dly < 0);
        s       = w + 12 + t.resp_dly;
        if (!t.is_read)  end_c = w + 12;
        else if (tmo)    end_c = w + 12 + TMO;
        else             end_c = s + 8;
        last_wr = tmo ? end_c - 1 : s;

        idle_inputs();
        start_read  = t.is_read;
        start_write = !t.is_read;
        addr_in     = t.addr;
        wdata_in    = t.wdata;
        obs_end     = -1;

        for (int c = 0; c <= end_c + 1; c++) begin
            @(posedge clk);
            #1;
            i      = c - w;
            e_mv   = (c >= w) && (c < w + 12);
            e_busy = (c < end_c) || ((c == end_c) && !tmo);
            e_done = (c == end_c) && !tmo;
            e_err  = (c == end_c) && tmo;
            e_en   = (c < w + 12);
            e_txa  = e_mv ? t.addr[i] : 1'b0;
            e_txd  = (e_mv && !t.is_read && (i < 8)) ? t.wdata[i] : 1'b0;
            e_mr   = t.is_read && (c >= w + 12) && (c < end_c);
            e_sw   = t.is_read && (t.split_at >= 0) && (c > w + 12 + t.split_at) &&
                     (c <= last_wr);
            rd_exp = (t.is_read && !tmo && (c >= end_c)) ? t.rbits : mdl_rdata;
            exp    = {e_busy, e_done, e_err, e_en && t.is_read, e_en && !t.is_read,
                      e_mv, e_txa, e_txd, e_mr, e_sw, rd_exp};
            check("txn_cycle", c, sample(), exp);
            if ((done || error) && (obs_end < 0)) obs_end = c;

            // Inputs for cycle c; anything outside its window is noise the port must ignore.
            start_read      = (c < end_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            start_write     = (c < end_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            addr_in         = 12'($urandom);
            wdata_in        = 8'($urandom);
            bus.slave_ready = (c < w) ? (c >= t.rdy_dly) : 1'($urandom);
            bus.slave_valid = 1'($urandom);
            bus.rx_data     = 1'($urandom);
            bus.split_en    = 1'($urandom);
            if (t.is_read && (c >= w + 12) && (c <= last_wr)) begin
                bus.slave_valid = !tmo && (c == s);
                if (!tmo && (c == s)) bus.rx_data = t.rbits[0];
                bus.split_en = (c == w + 12 + t.split_at);
            end else if (t.is_read && !tmo && (c > s) && (c <= s + 7)) begin
                bus.rx_data = t.rbits[c - s];
            end
        end
        if (t.is_read && !tmo) mdl_rdata = t.rbits;
        idle_inputs();
    endtask

    initial begin
        vec_t        tbl [5];
        vec_t        rv;
        int          obs;
        logic [11:0] ra;
        logic [7:0]  wd;

        tbl[0] = '{1'b0, 12'hA5C, 8'h3B, 8'h00, 0,  0, -1, 13, 8'h00};
        tbl[1] = '{1'b1, 12'h012, 8'h00, 8'h96, 0,  5, -1, 26, 8'h96};
        tbl[2] = '{1'b1, 12'h3C7, 8'h55, 8'hFF, 2, 14,  2, 37, 8'hFF};
        tbl[3] = '{1'b1, 12'h800, 8'h00, 8'hA1, 1, -1,  4, 30, 8'hFF};
        tbl[4] = '{1'b0, 12'hFFF, 8'h80, 8'h00, 3,  0, -1, 16, 8'hFF};

        reset    = 1'b1;
        addr_in  = '0;
        wdata_in = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 0, sample(), 18'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 5; k++) begin
            run_txn(tbl[k], obs);
            check_int("end_cycle", obs, tbl[k].exp_end);
            check_int("final_rdata", int'(rdata), int'(tbl[k].exp_rdata));
        end

        // Both requests at once: error pulse only, nothing starts.
        start_read  = 1'b1;
        start_write = 1'b1;
        addr_in     = 12'h123;
        @(posedge clk);
        #1;
        idle_inputs();
        check("both_start_err", 0, sample(), {3'b001, 7'b0, mdl_rdata});
        @(posedge clk);
        #1;
        check("both_start_after", 1, sample(), {10'b0, mdl_rdata});

        for (int n = 0; n < 25; n++) begin
            rv.is_read   = 1'($urandom_range(0, 1));
            rv.addr      = 12'($urandom);
            rv.wdata     = 8'($urandom);
            rv.rbits     = 8'($urandom);
            rv.rdy_dly   = $urandom_range(0, 3);
            rv.resp_dly  = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TMO - 1);
            rv.split_at  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, TMO - 1) : -1;
            rv.exp_end   = 0;
            rv.exp_rdata = 8'h00;
            run_txn(rv, obs);
        end

        // Reset while the write is on address bit 6 of SEND.
        ra          = 12'h5A5;
        wd          = 8'hC3;
        start_write = 1'b1;
        addr_in     = ra;
        wdata_in    = wd;
        bus.slave_ready = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            @(posedge clk);
            #1;
            start_write = 1'b0;
        end
        check("mid_send_bit6", 7,
              {13'b0, busy, bus.write_en, bus.master_valid, bus.tx_address, bus.tx_data},
              {13'b0, 1'b1, 1'b1, 1'b1, ra[6], wd[6]});
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_abort", 8, sample(), 18'h0);
        mdl_rdata = 8'h00;
        reset = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        check("reset_no_pulse", 9, sample(), 18'h0);

        rv = '{1'b0, 12'h6E1, 8'h5D, 8'h00, 1, 0, -1, 14, 8'h00};
        run_txn(rv, obs);
        check_int("post_reset_end", obs, rv.exp_end);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
